instr_prefetch_queue: RTL and testbench
=======================================

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter INSTR_W, default 16, instruction word width.
REQ-002 Parameter ADDR_W, default 16, fetch address width; word-addressed.
REQ-003 Parameter DEPTH, default 4, prefetch queue entries; power of two, >=2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 run  in  1  fetch enable; 0 blocks new memory requests only.
REQ-008 mem_req  out  1  request strobe; one-cycle issue of mem_addr.
REQ-009 mem_addr  out  ADDR_W  address of issued request.
REQ-010 mem_rvalid  in  1  response strobe for the outstanding request.
REQ-011 mem_rdata  in  INSTR_W  response instruction, valid with mem_rvalid.
REQ-012 run_core  out  1  head entry valid; core may execute instr.
REQ-013 instr  out  INSTR_W  head instruction.
REQ-014 instr_pc  out  ADDR_W  address of head instruction.
REQ-015 done  in  1  core retired head; pops queue.
REQ-016 branch_valid  in  1  redirect request.
REQ-017 branch_target  in  ADDR_W  redirect address.
REQ-018 count  out  $clog2(DEPTH+1)  queue occupancy.

Function
REQ-019 At most one memory request SHALL be outstanding.
REQ-020 mem_req SHALL be high iff run=1, no request outstanding, count+0<DEPTH, and branch_valid=0; mem_addr SHALL equal fetch_pc.
REQ-021 On a cycle with mem_req=1, fetch_pc SHALL increment by 1 modulo 2^ADDR_W (0xFFFF -> 0x0000) and outstanding SHALL set next cycle.
REQ-022 mem_rvalid SHALL complete the outstanding request; data and its address SHALL be pushed unless discard is pending; mem_rvalid with nothing outstanding SHALL be ignored.
REQ-023 Minimum latency: response in cycle N -> run_core=1 in cycle N+1; sustained throughput one instruction per 2 cycles at 1-cycle memory latency.
REQ-024 run_core SHALL equal (count!=0); instr/instr_pc SHALL show head entry; done with count=0 SHALL be ignored.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-026 Queue SHALL never overflow: space is reserved before issue, so push never occurs at count=DEPTH.
REQ-027 branch_valid SHALL, next cycle: empty the queue (count=0), set fetch_pc=branch_target, suppress mem_req in the branch cycle.
REQ-028 branch_valid with a request outstanding and no mem_rvalid that cycle SHALL set discard; the next mem_rvalid SHALL be dropped and clear discard and outstanding.
REQ-029 branch_valid coincident with mem_rvalid SHALL drop that response and SHALL NOT set discard.
REQ-030 branch_valid coincident with done SHALL behave as branch only.
REQ-031 branch_valid while discard pending SHALL keep discard set and retarget fetch_pc.
REQ-032 run=0 SHALL not cancel an outstanding request; its response SHALL still be pushed.

Reset
REQ-033 reset=0 at a rising edge SHALL set count=0, fetch_pc=RESET_PC, outstanding=0, discard=0; hence mem_req=0 and run_core=0 during reset.
REQ-034 Reset mid-request SHALL abandon it; a later stray mem_rvalid SHALL be ignored per REQ-022.

Structure
REQ-035 Default parameter values and the pointer/count width function SHALL live in shared package fetch_pkg.
REQ-036 Queue storage SHALL be a sub-module sync_fifo (parameters WIDTH=INSTR_W+ADDR_W, DEPTH) with push, pop, flush, count.

Verification
REQ-037 Reset release, run=1, memory answers in 1 cycle with rdata=0x1000+addr -> mem_addr 0,1,2,3; instr 0x1000..0x1003 in order with instr_pc 0..3.
REQ-038 done held 0, DEPTH=4 -> exactly 4 requests, count=4, mem_req stays 0; one done -> exactly one new request.
REQ-039 Request to addr 5 outstanding, branch_valid with target 0x0040, response 2 cycles later -> response dropped, next mem_addr=0x0040, count=0 meanwhile.
REQ-040 branch_valid with mem_rvalid and done same cycle, count=2 -> count=0 next cycle, discard=0, next mem_addr=branch_target.
REQ-041 RESET_PC=0xFFFE -> mem_addr 0xFFFE, 0xFFFF, 0x0000.
REQ-042 run dropped while request outstanding -> response pushed, no further mem_req until run=1; reset asserted with count=3 -> count=0, run_core=0 next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults and sizing helpers for the instruction prefetch queue
package fetch_pkg;

  localparam int INSTR_W_DEF  = 16;
  localparam int ADDR_W_DEF   = 16;
  localparam int DEPTH_DEF    = 4;
  localparam int RESET_PC_DEF = 0;

  // Pointer width for a power-of-two queue; never zero so DEPTH=1 still elaborates.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// rtl/instr_prefetch_queue_if.sv - memory fetch port and core-facing queue port
interface instr_prefetch_queue_if
  import fetch_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) ();

  logic                        run;
  logic                        mem_req;
  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_rvalid;
  logic [INSTR_W-1:0]          mem_rdata;
  logic                        run_core;
  logic [INSTR_W-1:0]          instr;
  logic [ADDR_W-1:0]           instr_pc;
  logic                        done;
  logic                        branch_valid;
  logic [ADDR_W-1:0]           branch_target;
  logic [cnt_w(DEPTH)-1:0]     count;

  modport master (
    input  run, mem_rvalid, mem_rdata, done, branch_valid, branch_target,
    output mem_req, mem_addr, run_core, instr, instr_pc, count
  );

  modport slave (
    output run, mem_rvalid, mem_rdata, done, branch_valid, branch_target,
    input  mem_req, mem_addr, run_core, instr, instr_pc, count
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two synchronous FIFO with flush and occupancy count
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - single-outstanding instruction fetcher feeding a prefetch queue
module instr_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input logic                    clk,
  input logic                    reset,
  instr_prefetch_queue_if.master bus
);

  localparam int CW = cnt_w(DEPTH);

  logic [ADDR_W-1:0]         fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]         req_addr_q, req_addr_d;
  logic                      outstanding_q, outstanding_d;
  logic                      discard_q, discard_d;
  logic                      mem_req, accept, push, pop;
  logic [CW-1:0]             count;
  logic [INSTR_W+ADDR_W-1:0] wdata, rdata;

  always_comb begin
    // A slot is effectively reserved at issue: only one request can be in flight.
    mem_req       = reset && bus.run && !outstanding_q && (count < CW'(DEPTH))
                    && !bus.branch_valid;
    accept        = bus.mem_rvalid && outstanding_q;
    push          = accept && !discard_q && !bus.branch_valid;
    pop           = bus.done && (count != '0) && !bus.branch_valid;
    wdata         = {bus.mem_rdata, req_addr_q};

    fetch_pc_d    = fetch_pc_q;
    req_addr_d    = req_addr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (accept) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
    end
    if (mem_req) begin
      outstanding_d = 1'b1;
      req_addr_d    = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 1'b1;
    end
    // A redirect with a response still in flight must swallow that stale response.
    if (bus.branch_valid) begin
      fetch_pc_d = bus.branch_target;
      if (outstanding_q && !accept) begin
        discard_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q    <= ADDR_W'(RESET_PC);
      req_addr_q    <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_addr_q    <= req_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH (INSTR_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.branch_valid),
    .wdata (wdata),
    .rdata (rdata),
    .count (count)
  );

  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = fetch_pc_q;
  assign bus.run_core = (count != '0);
  assign bus.instr    = rdata[INSTR_W+ADDR_W-1:ADDR_W];
  assign bus.instr_pc = rdata[ADDR_W-1:0];
  assign bus.count    = count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - directed self-checking bench for instr_prefetch_queue
module tb_instr_prefetch_queue;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset, reset2;
  always #5 clk = ~clk;

  instr_prefetch_queue_if #(.INSTR_W(16), .ADDR_W(16), .DEPTH(4)) bus ();
  instr_prefetch_queue_if #(.INSTR_W(16), .ADDR_W(16), .DEPTH(4)) bus2 ();

  instr_prefetch_queue #(.INSTR_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  instr_prefetch_queue #(.INSTR_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC('hFFFE)) dut2 (
    .clk(clk), .reset(reset2), .bus(bus2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic        auto_mem, man_rvalid;
  logic [15:0] man_rdata;
  logic        resp_v = 1'b0, resp2_v = 1'b0;
  logic [15:0] resp_a = '0, resp2_a = '0;
  logic [15:0] log1 [64];
  logic [15:0] log2 [8];
  int          req_cnt = 0, req2_cnt = 0;

  // One-cycle memory models answering with 0x1000 + address.
  always @(posedge clk) begin
    resp_v  <= bus.mem_req;
    resp_a  <= bus.mem_addr;
    resp2_v <= bus2.mem_req;
    resp2_a <= bus2.mem_addr;
    if (bus.mem_req && req_cnt < 64) begin
      log1[req_cnt] <= bus.mem_addr;
      req_cnt       <= req_cnt + 1;
    end
    if (bus2.mem_req && req2_cnt < 8) begin
      log2[req2_cnt] <= bus2.mem_addr;
      req2_cnt       <= req2_cnt + 1;
    end
  end

  assign bus.mem_rvalid     = auto_mem ? resp_v : man_rvalid;
  assign bus.mem_rdata      = auto_mem ? 16'h1000 + resp_a : man_rdata;
  assign bus2.mem_rvalid    = resp2_v;
  assign bus2.mem_rdata     = 16'h1000 + resp2_a;
  assign bus2.run           = 1'b1;
  assign bus2.done          = 1'b0;
  assign bus2.branch_valid  = 1'b0;
  assign bus2.branch_target = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; reset2 = 1'b0;
    auto_mem = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
    bus.run = 1'b1; bus.done = 1'b0; bus.branch_valid = 1'b0; bus.branch_target = '0;
    tick(); tick(); #1;
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_run_core", 32'(bus.run_core), 0);
    chk("rst_count", 32'(bus.count), 0);

    // Reset release with 1-cycle memory: first request, then latency.
    reset = 1'b1; auto_mem = 1'b1; #1;
    chk("first_mem_req", 32'(bus.mem_req), 1);
    chk("first_mem_addr", 32'(bus.mem_addr), 0);
    tick(); #1;
    chk("lat_run_core_early", 32'(bus.run_core), 0);
    tick(); #1;
    chk("lat_run_core", 32'(bus.run_core), 1);
    chk("lat_instr", 32'(bus.instr), 32'h1000);

    // Fill with done held low: exactly DEPTH requests.
    for (int i = 0; i < 40 && bus.count != 3'd4; i++) tick();
    #1;
    chk("fill_count", 32'(bus.count), 4);
    repeat (6) tick();
    #1;
    chk("fill_req_cnt", 32'(req_cnt), 4);
    chk("fill_mem_req", 32'(bus.mem_req), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("fill_addr%0d", i), 32'(log1[i]), 32'(i));
    chk("head_instr0", 32'(bus.instr), 32'h1000);
    chk("head_pc0", 32'(bus.instr_pc), 0);

    // One done frees exactly one slot.
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    repeat (5) tick();
    #1;
    chk("one_done_req_cnt", 32'(req_cnt), 5);
    chk("one_done_addr", 32'(log1[4]), 4);
    chk("one_done_count", 32'(bus.count), 4);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("order_instr%0d", k), 32'(bus.instr), 32'h1000 + 32'(k));
      chk($sformatf("order_pc%0d", k), 32'(bus.instr_pc), 32'(k));
      bus.done = 1'b1; tick(); bus.done = 1'b0; tick(); #1;
    end

    // Manual memory from here on.
    auto_mem = 1'b0; reset = 1'b0; bus.run = 1'b0;
    tick(); tick();
    reset = 1'b1;

    // Branch to 5, issue, then redirect to 0x40 while outstanding.
    bus.branch_valid = 1'b1; bus.branch_target = 16'h0005;
    tick();
    bus.branch_valid = 1'b0; bus.run = 1'b1; #1;
    chk("br_issue_req", 32'(bus.mem_req), 1);
    chk("br_issue_addr", 32'(bus.mem_addr), 32'h5);
    tick();
    bus.branch_valid = 1'b1; bus.branch_target = 16'h0040; #1;
    chk("br_suppress_req", 32'(bus.mem_req), 0);
    tick();
    bus.branch_valid = 1'b0; #1;
    chk("disc_count", 32'(bus.count), 0);
    chk("disc_mem_req", 32'(bus.mem_req), 0);
    tick();
    man_rvalid = 1'b1; man_rdata = 16'hBEEF;
    tick();
    man_rvalid = 1'b0; #1;
    chk("disc_dropped_count", 32'(bus.count), 0);
    chk("disc_next_req", 32'(bus.mem_req), 1);
    chk("disc_next_addr", 32'(bus.mem_addr), 32'h40);

    // Two entries, then branch + rvalid + done together.
    tick(); man_rvalid = 1'b1; man_rdata = 16'h2040;
    tick(); man_rvalid = 1'b0;
    tick(); man_rvalid = 1'b1; man_rdata = 16'h2041;
    tick(); man_rvalid = 1'b0; #1;
    chk("two_count", 32'(bus.count), 2);
    chk("two_instr", 32'(bus.instr), 32'h2040);
    chk("two_pc", 32'(bus.instr_pc), 32'h40);
    tick();
    man_rvalid = 1'b1; man_rdata = 16'h2042;
    bus.branch_valid = 1'b1; bus.branch_target = 16'h0080; bus.done = 1'b1; #1;
    chk("combo_req", 32'(bus.mem_req), 0);
    tick();
    man_rvalid = 1'b0; bus.branch_valid = 1'b0; bus.done = 1'b0; #1;
    chk("combo_count", 32'(bus.count), 0);
    chk("combo_run_core", 32'(bus.run_core), 0);
    chk("combo_req_after", 32'(bus.mem_req), 1);
    chk("combo_addr", 32'(bus.mem_addr), 32'h80);
    tick(); man_rvalid = 1'b1; man_rdata = 16'h2080;
    tick(); man_rvalid = 1'b0; #1;
    chk("no_discard_count", 32'(bus.count), 1);
    chk("no_discard_instr", 32'(bus.instr), 32'h2080);
    chk("no_discard_pc", 32'(bus.instr_pc), 32'h80);

    // Stray rvalid with nothing outstanding.
    bus.run = 1'b0;
    tick(); man_rvalid = 1'b1; man_rdata = 16'hDEAD;
    tick(); man_rvalid = 1'b0; #1;
    chk("stray_count", 32'(bus.count), 1);

    // run dropped while outstanding: response still lands, no new request.
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0; man_rvalid = 1'b1; man_rdata = 16'h2081;
    tick(); man_rvalid = 1'b0; #1;
    chk("runoff_count", 32'(bus.count), 2);
    chk("runoff_req", 32'(bus.mem_req), 0);
    tick(); #1;
    chk("runoff_req_hold", 32'(bus.mem_req), 0);
    bus.run = 1'b1; #1;
    chk("runon_req", 32'(bus.mem_req), 1);
    chk("runon_addr", 32'(bus.mem_addr), 32'h82);
    tick();
    bus.run = 1'b0; man_rvalid = 1'b1; man_rdata = 16'h2082;
    tick(); man_rvalid = 1'b0; #1;
    chk("three_count", 32'(bus.count), 3);
    chk("three_run_core", 32'(bus.run_core), 1);
    reset = 1'b0;
    tick(); #1;
    chk("rst3_count", 32'(bus.count), 0);
    chk("rst3_run_core", 32'(bus.run_core), 0);
    chk("rst3_mem_req", 32'(bus.mem_req), 0);

    // Reset mid-request abandons it; the late response is ignored.
    reset = 1'b1; bus.run = 1'b1;
    tick();
    reset = 1'b0; bus.run = 1'b0;
    tick();
    reset = 1'b1; man_rvalid = 1'b1; man_rdata = 16'h3333;
    tick(); man_rvalid = 1'b0; #1;
    chk("rst_mid_count", 32'(bus.count), 0);
    chk("rst_mid_run_core", 32'(bus.run_core), 0);

    // RESET_PC near the top of the address space wraps.
    reset2 = 1'b1;
    repeat (8) tick();
    #1;
    chk("wrap_addr0", 32'(log2[0]), 32'hFFFE);
    chk("wrap_addr1", 32'(log2[1]), 32'hFFFF);
    chk("wrap_addr2", 32'(log2[2]), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
